// File: rtl/sample_serial_transmitter.sv
// Buffers 16-bit mono samples in a small FIFO and streams them to an I2S DAC
// as stereo frames (same sample on both channels), with its own BCLK/LRCLK.
module sample_serial_transmitter #(
  parameter int BCLK_HALF_PERIOD = 8,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_SampleReady,
  input  logic signed [15:0]            i_Sample,
  output logic                          o_BitClock,
  output logic                          o_WordSelect,
  output logic                          o_SerialData,
  output logic                          o_Overflow,
  output logic                          o_Underflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_FifoLevel
);

  localparam int DW = $clog2(BCLK_HALF_PERIOD);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_LAST   = DW'(BCLK_HALF_PERIOD - 1);
  localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);

  logic [DW-1:0] div_count;
  logic [4:0]    slot;
  logic [4:0]    slot_next;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   held;
  logic [15:0]   head;
  logic [31:0]   shift;
  logic          div_wrap;
  logic          fall;
  logic          frame_start;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_ok;

  // A full FIFO still accepts a push when the frame start pops in the same cycle.
  always_comb begin
    div_wrap    = (div_count == DIV_LAST);
    fall        = div_wrap & o_BitClock;
    frame_start = fall & (slot == 5'd31);
    slot_next   = slot + 5'd1;
    empty       = (o_FifoLevel == '0);
    full        = (o_FifoLevel == FULL_LEVEL);
    pop         = frame_start & ~empty;
    push_ok     = i_SampleReady & (~full | pop);
    head        = mem[rd_ptr];
  end

  always_ff @(posedge i_Clock) begin
    if (push_ok && !i_Reset) begin
      mem[wr_ptr] <= i_Sample;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      div_count    <= '0;
      slot         <= 5'd31;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      held         <= '0;
      shift        <= '0;
      o_BitClock   <= 1'b0;
      o_WordSelect <= 1'b0;
      o_SerialData <= 1'b0;
      o_Overflow   <= 1'b0;
      o_Underflow  <= 1'b0;
      o_FifoLevel  <= '0;
    end else begin
      div_count   <= div_wrap ? '0 : div_count + 1'b1;
      if (div_wrap) begin
        o_BitClock <= ~o_BitClock;
      end
      o_Overflow  <= i_SampleReady & full & ~pop;
      o_Underflow <= frame_start & empty;

      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_ok, pop})
        2'b10:   o_FifoLevel <= o_FifoLevel + 1'b1;
        2'b01:   o_FifoLevel <= o_FifoLevel - 1'b1;
        default: o_FifoLevel <= o_FifoLevel;
      endcase

      // The MSB shifted out at slot 0 is still the previous frame's right LSB.
      if (fall) begin
        slot         <= slot_next;
        o_WordSelect <= slot_next[4];
        o_SerialData <= shift[31];
        if (frame_start) begin
          if (pop) begin
            held  <= head;
            shift <= {head, head};
          end else begin
            shift <= {held, held};
          end
        end else begin
          shift <= {shift[30:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_sample_serial_transmitter.sv
// Directed bench for sample_serial_transmitter: tracks BCLK falls itself to
// collect each frame's serial bits and compares them with hand-derived words.
module tb_sample_serial_transmitter;

  localparam int H     = 2;
  localparam int D     = 4;
  localparam int FRAME = 64 * H;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sample_ready = 1'b0;
  logic [15:0] sample = 16'h0000;
  logic        bit_clock;
  logic        word_select;
  logic        serial_data;
  logic        overflow;
  logic        underflow;
  logic [2:0]  fifo_level;

  always #5 clock = ~clock;

  sample_serial_transmitter #(.BCLK_HALF_PERIOD(H), .FIFO_DEPTH(D)) dut (
    .i_Clock      (clock),
    .i_Reset      (reset),
    .i_SampleReady(sample_ready),
    .i_Sample     (sample),
    .o_BitClock   (bit_clock),
    .o_WordSelect (word_select),
    .o_SerialData (serial_data),
    .o_Overflow   (overflow),
    .o_Underflow  (underflow),
    .o_FifoLevel  (fifo_level)
  );

  int          checks = 0;
  int          errors = 0;
  int          cycles = 0;
  int          ws_err = 0;
  int          stray_uf = 0;
  int          ov_total = 0;
  logic [4:0]  slot = 5'd31;
  logic        prev_bclk = 1'b0;
  logic [31:0] cap = '0;
  logic [31:0] last_cap = '0;
  logic        last_uf = 1'b0;
  logic        frame_done = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cycles);
    end
  endtask

  // One clock; #1 after the edge, follow the bench's own slot count on BCLK falls.
  task automatic tick();
    logic r;
    logic fell;
    r = reset;
    @(posedge clock);
    #1;
    if (r) begin
      cycles    = 0;
      slot      = 5'd31;
      prev_bclk = 1'b0;
    end else begin
      cycles++;
      if (overflow === 1'b1) ov_total++;
      fell = (prev_bclk === 1'b1) && (bit_clock === 1'b0);
      if (fell) begin
        slot = slot + 5'd1;
        cap  = {cap[30:0], serial_data};
        if (word_select !== slot[4]) ws_err++;
        if (slot == 5'd0) begin
          frame_done = 1'b1;
          last_cap   = cap;
          last_uf    = underflow;
        end
      end
      if (underflow === 1'b1 && !(fell && slot == 5'd0)) stray_uf++;
      prev_bclk = bit_clock;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] v);
    sample_ready = 1'b1;
    sample       = v;
    tick();
    sample_ready = 1'b0;
  endtask

  task automatic waitFrame();
    int n;
    frame_done = 1'b0;
    n = 0;
    while (!frame_done && n < FRAME + 16) begin
      tick();
      n++;
    end
    checkOutput("frame_timeout", frame_done, 1);
  endtask

  // Slots 1..31 plus the next slot 0 of a frame carrying s read back as {s,s}.
  task automatic checkFrame(input string tag, input logic [15:0] s, input logic uf_next);
    waitFrame();
    checkOutput({tag, "_data"}, last_cap, {s, s});
    checkOutput({tag, "_uf"}, last_uf, uf_next);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_bclk"}, bit_clock, 0);
    checkOutput({tag, "_ws"}, word_select, 0);
    checkOutput({tag, "_sdata"}, serial_data, 0);
    checkOutput({tag, "_ov"}, overflow, 0);
    checkOutput({tag, "_uf"}, underflow, 0);
    checkOutput({tag, "_level"}, fifo_level, 0);
  endtask

  task automatic checkRelease();
    reset        = 1'b0;
    sample_ready = 1'b0;
    for (int c = 1; c <= 2 * H; c++) begin
      tick();
      checkOutput("bclk_release", bit_clock, (c >= H && c < 2 * H));
    end
    checkOutput("release_uf", underflow, 1);
    checkOutput("release_ws", word_select, 0);
    checkOutput("release_sdata", serial_data, 0);
  endtask

  logic [15:0] collide_vals [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};

  initial begin
    int n;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample_ready = (i != 1);
      sample       = 16'h1000 + 16'(i);
      tick();
    end
    sample_ready = 1'b0;
    checkAllZero("reset");
    checkRelease();

    applyStimulus(16'hA5C3);
    checkOutput("level_push", fifo_level, 1);
    checkFrame("f0_empty", 16'h0000, 1'b0);
    checkOutput("level_pop", fifo_level, 0);
    checkFrame("f1_a5c3", 16'hA5C3, 1'b1);

    applyStimulus(16'h8001);
    checkFrame("f2_repeat", 16'hA5C3, 1'b0);
    checkFrame("f3_8001", 16'h8001, 1'b1);

    for (int i = 1; i <= 5; i++) begin
      applyStimulus(16'(i));
      checkOutput("ov_push", overflow, (i == 5));
      checkOutput("level_fill", fifo_level, (i < 4) ? i : 4);
    end
    tick();
    checkOutput("ov_once", overflow, 0);
    checkOutput("level_full", fifo_level, 4);
    checkFrame("f4_repeat", 16'h8001, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      checkFrame("fifo_order", 16'(i), (i == 4));
    end

    for (int i = 0; i < 4; i++) begin
      applyStimulus(collide_vals[i]);
      checkOutput("ov_refill", overflow, 0);
    end
    checkOutput("level_refill", fifo_level, 4);
    frame_done = 1'b0;
    while (cycles < 2 * H + FRAME * 10 - 1) tick();
    applyStimulus(collide_vals[4]);
    checkOutput("coll_start", frame_done, 1);
    checkOutput("coll_ov", overflow, 0);
    checkOutput("coll_level", fifo_level, 4);
    checkOutput("coll_uf", underflow, 0);
    checkOutput("coll_prev", last_cap, {16'h0004, 16'h0004});
    for (int k = 0; k < 5; k++) begin
      checkFrame("coll_order", collide_vals[k], (k == 4));
    end

    applyStimulus(16'h7777);
    applyStimulus(16'h1234);
    checkOutput("level_two", fifo_level, 2);
    n = 0;
    while (slot != 5'd9 && n < FRAME) begin
      tick();
      n++;
    end
    checkOutput("reach_slot9", slot, 9);
    reset        = 1'b1;
    sample_ready = 1'b1;
    tick();
    checkAllZero("midrst");
    sample_ready = 1'b0;
    tick();
    checkRelease();
    checkFrame("post_rst", 16'h0000, 1'b1);

    checkOutput("ws_slots", ws_err, 0);
    checkOutput("stray_uf", stray_uf, 0);
    checkOutput("ov_total", ov_total, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
